// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end.  Keeps at most one instruction-bus request
// outstanding and stores the returned {pc, instr} pairs in a small circular
// FIFO that decode drains.  A pipeline redirect flushes the FIFO and restarts
// fetching at the new PC.  A response that was already in flight when the
// redirect arrived is waited out and discarded.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-high reset
//   ireq         : instruction bus request {valid, addr}
//   iresp        : instruction bus response {data_ok, data}
//   redirect     : branch/jump flush from the pipeline
//   redirect_pc  : new fetch address, qualified by redirect
//   out_valid    : head entry of the queue is available
//   out_ready    : decode accepts the head entry this cycle
//   out_pc       : PC of the head entry
//   out_instr    : raw instruction of the head entry
//   count        : number of occupied queue entries
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    output ibus_req_t                    ireq,
    input  ibus_resp_t                   iresp,
    input  logic                         redirect,
    input  logic [63:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_pc,
    output logic [31:0]                  out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: nothing outstanding; REQ: outstanding, result is kept;
    // DROP: outstanding, result is thrown away (fetch was redirected).
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [63:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            pop;
    logic            push;
    logic [CW-1:0]   count_after_pop;
    logic [CW-1:0]   count_after_push;

    // A redirect kills both the pop and the push of its cycle, so the
    // flushed queue really is empty afterwards.
    always_comb begin
        pop              = (count_q != '0) && out_ready && !redirect;
        push             = (state_q == REQ) && iresp.data_ok && !redirect;
        count_after_pop  = count_q - CW'(pop);
        count_after_push = count_after_pop + CW'(push);
    end

    // Next-state logic.  A new request is started only when a slot is free
    // after this cycle's pop, which reserves room for the response and makes
    // overflow impossible with a single outstanding request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect && (count_after_pop < DEPTH_C)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = iresp.data_ok ? IDLE : DROP;
                end else if (iresp.data_ok) begin
                    state_d = (count_after_push < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                // A further redirect without data_ok keeps waiting here.
                if (iresp.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: fetch PC, request address, pointers and count.
    // The request address only changes when a fresh request is launched, so
    // it stays stable for the whole life of an outstanding request.
    always_comb begin
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = addr_q + 64'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_after_push;
        end

        if ((state_q == IDLE) && (state_d == REQ)) begin
            addr_d = fetch_pc_q;
        end else if ((state_q == REQ) && (state_d == REQ) && push) begin
            // Back-to-back streaming: next sequential address, no bubble.
            addr_d = addr_q + 64'd4;
        end
    end

    // Output logic, all taken straight from registered state.
    always_comb begin
        ireq       = '0;
        ireq.valid = (state_q == REQ) || (state_q == DROP);
        ireq.addr  = addr_q;
        out_valid  = (count_q != '0);
        out_pc     = pc_mem[rd_ptr_q];
        out_instr  = instr_mem[rd_ptr_q];
        count      = count_q;
    end

    // State register.  Reset simply abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]    <= addr_q;
            instr_mem[wr_ptr_q] <= iresp.data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Scoreboard bench for fetch_queue.  Three processes share the work:
//   stimulus  : drives reset/redirect/out_ready at the falling edge
//   responder : plays the instruction bus (data = addr[31:0]) and pushes the
//               entries that must reach decode into the expected queue
//   monitor   : on every pop compares the head entry with the expected queue
//               and compares count with the expected queue depth
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic                        clk;
    logic                        reset;
    logic                        redirect;
    logic [63:0]                 redirectPc;
    logic                        outValid;
    logic                        outReady;
    logic [63:0]                 outPc;
    logic [31:0]                 outInstr;
    logic [$clog2(DEPTH+1)-1:0]  count;
    ibus_req_t                   ireq;
    ibus_resp_t                  iresp;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [63:0] expQ[$];
    logic [63:0] nextAddr   = RESET_PC;
    logic [63:0] heldAddr   = '0;
    bit          dropping   = 0;
    bit          reqActive  = 0;
    bit          respHold   = 0;
    int          respLatency = 0;
    int          waitCnt    = 0;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iresp       (iresp),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_pc      (outPc),
        .out_instr   (outInstr),
        .count       (count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; they act on the next
    // rising edge.
    task automatic applyStimulus(input logic rst, input logic rdr,
                                 input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        reset      = rst;
        redirect   = rdr;
        redirectPc = rpc;
        outReady   = rdy;
    endtask

    // Monitor: runs 1 time unit after the falling edge, before the responder
    // updates the expected queue for the coming rising edge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                checkOutput("count", 64'(count), 64'(expQ.size()));
                if (outValid && outReady && !redirect) begin
                    if (expQ.size() == 0) begin
                        checkOutput("pop_unexpected", 64'(outValid), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pop_pc", outPc, e);
                        checkOutput("pop_instr", 64'(outInstr), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    // Bus responder and reference model of what gets enqueued.
    initial begin
        bit okNow;
        iresp = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                iresp.data_ok = 1'b0;
                reqActive     = 0;
                dropping      = 0;
                waitCnt       = 0;
                nextAddr      = RESET_PC;
                expQ.delete();
            end else begin
                okNow = 0;
                if (ireq.valid) begin
                    if (!reqActive) begin
                        reqActive = 1;
                        heldAddr  = ireq.addr;
                        waitCnt   = 0;
                        if (!dropping) begin
                            checkOutput("req_addr", ireq.addr, nextAddr);
                        end
                    end else begin
                        checkOutput("addr_hold", ireq.addr, heldAddr);
                    end
                    okNow = !respHold && (waitCnt >= respLatency);
                    waitCnt++;
                end else begin
                    reqActive = 0;
                end
                iresp.data_ok = okNow;
                iresp.data    = ireq.addr[31:0];
                if (okNow) begin
                    reqActive = 0;
                end
                if (redirect) begin
                    expQ.delete();
                    nextAddr = redirectPc;
                    dropping = ireq.valid && !okNow;
                end else if (okNow) begin
                    if (!dropping) begin
                        expQ.push_back(ireq.addr);
                        nextAddr = ireq.addr + 64'd4;
                    end
                    dropping = 0;
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        bit          rdr;
        logic [63:0] rpc;
        reset      = 1'b1;
        redirect   = 1'b0;
        redirectPc = '0;
        outReady   = 1'b0;

        // Reset values.
        applyStimulus(1, 0, 64'h0, 1);
        applyStimulus(1, 0, 64'h0, 1);
        checkOutput("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        checkOutput("rst_ireq_addr", ireq.addr, 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);

        // Streaming from RESET_PC, data every cycle, decode always ready.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
            if (i == 1) begin
                checkOutput("first_req_addr", ireq.addr, 64'h8000_0000);
            end
            if (i >= 2) begin
                checkOutput("stream_valid", 64'(outValid), 64'd1);
            end
        end

        // Fill with decode stalled: exactly DEPTH pushes, then no request.
        applyStimulus(1, 0, 64'h0, 0);
        applyStimulus(1, 0, 64'h0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 64'h0, 0);
        end
        checkOutput("full_count", 64'(count), 64'd4);
        checkOutput("full_idle", 64'(ireq.valid), 64'd0);
        checkOutput("full_head_pc", outPc, 64'h8000_0000);
        applyStimulus(0, 0, 64'h0, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("refill_valid", 64'(ireq.valid), 64'd1);
        checkOutput("refill_addr", ireq.addr, 64'h8000_0010);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        // Redirect while a slow response is outstanding.
        applyStimulus(0, 0, 64'h0, 1);
        respHold = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end
        applyStimulus(0, 1, 64'h8000_1000, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("rdr_count", 64'(count), 64'd0);
        checkOutput("rdr_drop_valid", 64'(ireq.valid), 64'd1);
        applyStimulus(0, 0, 64'h0, 1);
        respHold = 0;
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("drop_done_count", 64'(count), 64'd0);
        checkOutput("drop_done_idle", 64'(ireq.valid), 64'd0);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("post_drop_valid", 64'(ireq.valid), 64'd1);
        checkOutput("post_drop_addr", ireq.addr, 64'h8000_1000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        // Redirect coincident with data_ok and a pop.
        applyStimulus(0, 1, 64'h8000_4000, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("coinc_count", 64'(count), 64'd0);
        checkOutput("coinc_idle", 64'(ireq.valid), 64'd0);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("coinc_next_addr", ireq.addr, 64'h8000_4000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        // Two redirects during one DROP: the newest target wins.
        applyStimulus(0, 0, 64'h0, 1);
        respHold = 1;
        applyStimulus(0, 1, 64'h8000_2000, 1);
        applyStimulus(0, 0, 64'h0, 1);
        applyStimulus(0, 1, 64'h8000_3000, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("drop2_valid", 64'(ireq.valid), 64'd1);
        respHold = 0;
        applyStimulus(0, 0, 64'h0, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("drop2_next_addr", ireq.addr, 64'h8000_3000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        // 64-bit wrap of the fetch PC.
        applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        // Reset while a request is outstanding: it is abandoned.
        applyStimulus(0, 0, 64'h0, 1);
        respHold = 1;
        applyStimulus(0, 0, 64'h0, 1);
        applyStimulus(1, 0, 64'h0, 1);
        respHold = 0;
        applyStimulus(1, 0, 64'h0, 1);
        applyStimulus(0, 0, 64'h0, 1);
        applyStimulus(0, 0, 64'h0, 1);
        checkOutput("post_reset_valid", 64'(ireq.valid), 64'd1);
        checkOutput("post_reset_addr", ireq.addr, RESET_PC);

        // Mixed phase: varying latency, stalls and occasional redirects.
        for (int i = 0; i < 300; i++) begin
            rdr = ($urandom_range(0, 19) == 0);
            rpc = 64'h9000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
            applyStimulus(0, rdr, rpc, ($urandom_range(0, 2) != 0));
            respLatency = int'($urandom_range(0, 3));
        end
        respLatency = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 64'h0, 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
